// File: rtl/fix_pkg.sv
// fix_pkg: shared Q3.3 constants, FSM encoding and round/saturate helper.
// Provides DW/FRAC/ACC_W, Q3.3 limits, state_t {ACCUM, FLUSH, OUT}, rs_t and round_sat().
package fix_pkg;
    localparam int DW    = 7;
    localparam int FRAC  = 3;
    localparam int ACC_W = 18;
    localparam logic signed [DW-1:0] Q_MAX = DW'(63);
    localparam logic signed [DW-1:0] Q_MIN = DW'(-64);
    localparam logic signed [ACC_W-1:0] A_MAX = ACC_W'(Q_MAX);
    localparam logic signed [ACC_W-1:0] A_MIN = ACC_W'(Q_MIN);
    localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1 << (FRAC - 1));
    typedef enum logic [1:0] {ACCUM, FLUSH, OUT} state_t;
    typedef struct packed {
        logic          sat;
        logic [DW-1:0] data;
    } rs_t;
    // Round half-up (toward +inf) from Q6.6-scaled accumulator to Q3.3, then clip.
    function automatic rs_t round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] r;
        rs_t o;
        r = (acc + HALF) >>> FRAC;
        o.sat  = r > A_MAX || r < A_MIN;
        o.data = r > A_MAX ? Q_MAX : r < A_MIN ? Q_MIN : r[DW-1:0];
        return o;
    endfunction
endpackage

// File: rtl/fix_round_sat.sv
// fix_round_sat: combinational ACC_W -> DW round-half-up with saturation flag.
// Ports: acc_i (signed accumulator, FRAC extra fraction bits), data_o (Q3.3), sat_o (clipped).
module fix_round_sat
    import fix_pkg::*;
(
    input  logic [ACC_W-1:0] acc_i,
    output logic [DW-1:0]    data_o,
    output logic             sat_o
);
    rs_t r;
    assign r      = round_sat($signed(acc_i));
    assign data_o = r.data;
    assign sat_o  = r.sat;
endmodule

// File: rtl/fix_neuron_mac.sv
// fix_neuron_mac: Q3.3 multiply-accumulate neuron with weight file, bias, round and saturate.
// Ports: clk/rst_n (async active-low), in_valid/in_ready/in_data activation stream,
// w_wr_en/w_wr_addr/w_wr_data weight writes, bias (sampled on first accept of a neuron),
// out_valid/out_ready/out_data/out_sat result stream.
module fix_neuron_mac
    import fix_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int AW       = $clog2(N_INPUTS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          w_wr_en,
    input  logic [AW-1:0] w_wr_addr,
    input  logic [DW-1:0] w_wr_data,
    input  logic [DW-1:0] bias,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_sat
);
    state_t                  state_q;
    logic [AW-1:0]           count_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [2*DW-1:0]  prod_q;
    logic                    prod_v_q, res_q, out_valid_q, out_sat_q;
    logic [DW-1:0]           out_data_q, rs_data;
    logic                    rs_sat;
    logic [DW-1:0]           w_q [N_INPUTS];
    logic                    accept, last;

    assign in_ready  = state_q == ACCUM;
    assign accept    = in_valid && in_ready;
    assign last      = count_q == AW'(N_INPUTS - 1);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    fix_round_sat u_rs (.acc_i(acc_q), .data_o(rs_data), .sat_o(rs_sat));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            count_q     <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            prod_v_q    <= 1'b0;
            res_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            for (int i = 0; i < N_INPUTS; i++) w_q[i] <= '0;
        end else begin
            // The accept below reads w_q before this write lands, so a same-cycle write is unseen.
            if (w_wr_en) w_q[w_wr_addr] <= w_wr_data;
            prod_v_q <= accept;
            if (accept) begin
                prod_q  <= (2*DW)'($signed(in_data)) * (2*DW)'($signed(w_q[count_q]));
                count_q <= last ? '0 : count_q + AW'(1);
            end
            // First accept of a neuron restarts the sum from the bias; the previous neuron's
            // last product was already absorbed during FLUSH, so nothing is lost here.
            if (accept && count_q == '0) acc_q <= ACC_W'($signed(bias)) <<< FRAC;
            else if (prod_v_q) acc_q <= acc_q + ACC_W'(prod_q);
            case (state_q)
                ACCUM: if (accept && last) state_q <= FLUSH;
                FLUSH: state_q <= OUT;
                default: begin
                    // OUT: register the rounded result one cycle after the final add, then raise
                    // out_valid the cycle after that (three edges after the last accept).
                    if (out_valid_q && out_ready) begin
                        state_q     <= ACCUM;
                        out_valid_q <= 1'b0;
                        res_q       <= 1'b0;
                        acc_q       <= '0;
                    end else if (res_q) begin
                        out_valid_q <= 1'b1;
                    end else begin
                        res_q      <= 1'b1;
                        out_data_q <= rs_data;
                        out_sat_q  <= rs_sat;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fix_neuron_mac.sv
// tb_fix_neuron_mac: randomized scoreboard bench for fix_neuron_mac against an arithmetic model.
module tb_fix_neuron_mac;
    localparam int N = 4;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       in_valid = 1'b0, in_ready;
    logic [6:0] in_data = '0;
    logic       w_wr_en = 1'b0;
    logic [1:0] w_wr_addr = '0;
    logic [6:0] w_wr_data = '0, bias = '0;
    logic       out_valid, out_ready = 1'b1, out_sat;
    logic [6:0] out_data;

    always #5 clk = ~clk;

    fix_neuron_mac #(.N_INPUTS(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    typedef struct {int data; bit sat; int when;} exp_t;
    exp_t sb[$];
    int   n_chk = 0, n_bad = 0, cyc = 0;
    int   mw[N];
    int   acc_m = 0, k = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, int act, int req);
        n_chk++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: exact sum in Q6.6, floor((s+4)/8), then clip to [-64, 63].
    function automatic exp_t model(int s, int when);
        exp_t e;
        int r;
        r = (s + 4) >>> 3;
        e.sat  = r > 63 || r < -64;
        e.data = r > 63 ? 63 : r < -64 ? -64 : r;
        e.when = when;
        return e;
    endfunction

    function automatic int rnd7();
        return int'($urandom_range(127)) - 64;
    endfunction

    task automatic send(int x, bit wr = 0, int wa = 0, int wd = 0);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_wait", int'(in_ready), 1);
        in_valid = 1'b1; in_data = 7'(x);
        w_wr_en = wr; w_wr_addr = 2'(wa); w_wr_data = 7'(wd);
        if (k == 0) acc_m = int'($signed(bias)) * 8;
        acc_m += x * mw[k];
        if (wr) mw[wa] = wd;
        k++;
        @(posedge clk);
        #1;
        in_valid = 1'b0; w_wr_en = 1'b0;
        if (k == N) begin
            sb.push_back(model(acc_m, cyc));
            k = 0;
        end
    endtask

    task automatic wr(int a, int d);
        @(negedge clk);
        w_wr_en = 1'b1; w_wr_addr = 2'(a); w_wr_data = 7'(d);
        @(posedge clk);
        #1;
        w_wr_en = 1'b0;
        mw[a] = d;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() > 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic wait_ov();
        int t = 0;
        while (!out_valid && t < 30) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("out_valid_seen", int'(out_valid), 1);
    endtask

    task automatic neuron(int b, int x0, int x1, int x2, int x3);
        bias = 7'(b);
        send(x0); send(x1); send(x2); send(x3);
        drain();
    endtask

    // Monitor: latency, hold stability under backpressure, in_ready low while presenting, data.
    logic       pov = 1'b0, ps = 1'b0, phs = 1'b0;
    logic [6:0] pd = '0;
    exp_t       me;
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !pov) begin
                if (sb.size() == 0) chk("unexpected_out", 1, 0);
                else chk("latency", cyc, sb[0].when + 3);
            end
            if (out_valid && pov && !phs) begin
                chk("hold_data", int'($signed(out_data)), int'($signed(pd)));
                chk("hold_sat", int'(out_sat), int'(ps));
            end
            if (out_valid) chk("in_ready_in_out", int'(in_ready), 0);
            if (out_valid && out_ready && sb.size() > 0) begin
                me = sb.pop_front();
                chk("out_data", int'($signed(out_data)), me.data);
                chk("out_sat", int'(out_sat), int'(me.sat));
            end
            pov = out_valid; pd = out_data; ps = out_sat; phs = out_valid && out_ready;
        end else begin
            pov = 1'b0; phs = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        foreach (mw[i]) mw[i] = 0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", int'(in_ready), 1);

        for (int i = 0; i < N; i++) wr(i, 8);
        neuron(0, 8, 16, 24, -8);
        for (int i = 0; i < N; i++) wr(i, 63);
        neuron(0, 63, 63, 63, 63);
        neuron(0, -64, -64, -64, -64);
        for (int i = 0; i < N; i++) wr(i, 0);
        wr(0, 4);
        neuron(0, 1, 0, 0, 0);
        neuron(0, -1, 0, 0, 0);
        neuron(-8, 0, 0, 0, 0);

        // Backpressure: result held 5 cycles while in_valid is asserted with junk.
        for (int i = 0; i < N; i++) wr(i, rnd7());
        @(posedge clk); #1 out_ready = 1'b0;
        bias = 7'(rnd7());
        for (int i = 0; i < N; i++) send(rnd7());
        wait_ov();
        @(negedge clk);
        in_valid = 1'b1; in_data = 7'(rnd7());
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b1;
        drain();
        neuron(5, rnd7(), rnd7(), rnd7(), rnd7());

        // Gaps, write between accepts, and same-cycle write at the accepting address.
        bias = 7'(rnd7());
        send(rnd7());
        repeat (2) @(posedge clk);
        send(rnd7());
        wr(2, rnd7());
        send(rnd7());
        repeat (3) @(posedge clk);
        send(rnd7(), 1'b1, 3, rnd7());
        drain();
        neuron(rnd7(), rnd7(), rnd7(), rnd7(), rnd7());

        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(1) == 1) wr(int'($urandom_range(N - 1)), rnd7());
            bias = 7'(rnd7());
            for (int i = 0; i < N; i++) begin
                repeat ($urandom_range(2)) @(posedge clk);
                send(rnd7(), $urandom_range(3) == 0, int'($urandom_range(N - 1)), rnd7());
            end
        end
        drain();

        // Reset after 2 of 4 accepts: partial sum and weights dropped.
        bias = 7'(3);
        send(rnd7()); send(rnd7());
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", int'(out_valid), 0);
        chk("rst_mid_in_ready", int'(in_ready), 1);
        k = 0;
        foreach (mw[i]) mw[i] = 0;
        #10 rst_n = 1'b1;
        neuron(-3, rnd7(), rnd7(), rnd7(), rnd7());
        for (int i = 0; i < N; i++) wr(i, rnd7());
        neuron(rnd7(), rnd7(), rnd7(), rnd7(), rnd7());

        // Reset while presenting a held result clears outputs asynchronously.
        for (int i = 0; i < N; i++) wr(i, 63);
        @(posedge clk); #1 out_ready = 1'b0;
        neuron_hold: begin
            bias = 7'(0);
            for (int i = 0; i < N; i++) send(63);
            wait_ov();
        end
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("rst_out_out_valid", int'(out_valid), 0);
        chk("rst_out_out_data", int'(out_data), 0);
        chk("rst_out_out_sat", int'(out_sat), 0);
        sb.delete();
        k = 0;
        foreach (mw[i]) mw[i] = 0;
        #10 rst_n = 1'b1;
        @(posedge clk); #1 out_ready = 1'b1;
        for (int i = 0; i < N; i++) wr(i, rnd7());
        neuron(rnd7(), rnd7(), rnd7(), rnd7(), rnd7());

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
